// File: rtl/noc_input_vc_buffer.sv
// Per-VC input buffering for one inter-router link: store flits, route each packet's head flit, and request the switch allocator.
// Latency: a HEAD pushed at edge t is in the FIFO head at t, the VC routes at t+1, and oreq rises at t+2. oack follows each pop by one cycle.
// Backpressure: upstream credits come from oack. A push into a full VC is dropped and sets the sticky oerr.
//
// Ports:
//   clk, reset      clock; synchronous active-low reset
//   idata/ivalid/ivch   incoming flit, its valid and its virtual channel
//   oack[NVC]       one-cycle credit per popped flit (granted or discarded)
//   olck[NVC]       VC holds an unfinished packet
//   oreq[NVC]       switch-allocator request; oport = routed port per VC
//   odata           FIFO head flit per VC (0 while empty)
//   igrant[NVC]     allocator grant, pops the head flit when oreq is set
//   oerr            sticky protocol/overflow error
module noc_input_vc_buffer #(
    parameter int ROUTERID   = 0,
    parameter int PORTID     = 0,
    parameter int NDIM       = 3,
    parameter int DATA_WIDTH = 32,
    parameter int NVC        = 4,
    parameter int VCW        = 2,
    parameter int DEPTH      = 5,
    parameter int TYPE_MSB   = 31,
    parameter int TYPE_LSB   = 30,
    parameter int DST_LSB    = 0,
    parameter int PORTW      = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     idata,
    input  logic                      ivalid,
    input  logic [VCW-1:0]            ivch,
    output logic [NVC-1:0]            oack,
    output logic [NVC-1:0]            olck,
    output logic [NVC-1:0]            oreq,
    output logic [NVC*PORTW-1:0]      oport,
    output logic [NVC*DATA_WIDTH-1:0] odata,
    input  logic [NVC-1:0]            igrant,
    output logic                      oerr
);
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam logic [PTRW-1:0] PTR_LAST = PTRW'(DEPTH - 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);
    localparam logic [NDIM-1:0] RID      = NDIM'(ROUTERID);

    localparam logic [1:0] FT_NONE = 2'b00;
    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_TAIL = 2'b11;

    // PORTID only tags the instance; a bad parameter set elaborates this empty block.
    if (PORTID < 0 || (1 << PORTW) <= NDIM) begin : g_bad_params
    end

    typedef enum logic [1:0] {VC_IDLE, VC_ROUTE, VC_ACTIVE} vc_state_t;

    vc_state_t             state_q  [NVC];
    vc_state_t             state_d  [NVC];
    logic [DATA_WIDTH-1:0] mem_q    [NVC][DEPTH];
    logic [DATA_WIDTH-1:0] mem_d    [NVC][DEPTH];
    logic [PTRW-1:0]       rd_ptr_q [NVC];
    logic [PTRW-1:0]       rd_ptr_d [NVC];
    logic [PTRW-1:0]       wr_ptr_q [NVC];
    logic [PTRW-1:0]       wr_ptr_d [NVC];
    logic [CNTW-1:0]       cnt_q    [NVC];
    logic [CNTW-1:0]       cnt_d    [NVC];
    logic [PORTW-1:0]      port_q   [NVC];
    logic [PORTW-1:0]      port_d   [NVC];
    logic [NVC-1:0]        ack_q, ack_d;
    logic [NVC-1:0]        lck_q, lck_d;
    logic                  err_q, err_d;

    logic [NVC-1:0]            push_v;   // valid flit addressed to this VC
    logic [NVC-1:0]            gpop_v;   // granted pop
    logic [NVC-1:0]            dpop_v;   // discard of a stray non-HEAD flit in IDLE
    logic [NVC-1:0]            pop_v;
    logic [NVC-1:0]            wr_v;     // push actually stored
    logic [NVC-1:0]            drop_v;
    logic [NVC-1:0][1:0]       head_type;
    logic [NVC-1:0][NDIM-1:0]  head_dst;
    logic [1:0]                in_type;

    assign in_type = idata[TYPE_MSB:TYPE_LSB];

    // Dimension-order hypercube routing: correct the lowest differing address bit first.
    function automatic logic [PORTW-1:0] route_port(input logic [NDIM-1:0] dst);
        logic [NDIM-1:0] diff;
        diff       = dst ^ RID;
        route_port = PORTW'(NDIM);
        for (int i = NDIM - 1; i >= 0; i--) begin
            if (diff[i]) route_port = PORTW'(i);
        end
    endfunction

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTRW'(1);
    endfunction

    for (genvar v = 0; v < NVC; v++) begin : g_vc
        logic [DATA_WIDTH-1:0] head;
        assign head         = mem_q[v][rd_ptr_q[v]];
        assign head_type[v] = head[TYPE_MSB:TYPE_LSB];
        assign head_dst[v]  = head[DST_LSB +: NDIM];

        assign oreq[v]   = (state_q[v] == VC_ACTIVE) && (cnt_q[v] != '0);
        assign push_v[v] = ivalid && (in_type != FT_NONE) && (ivch == VCW'(v));
        assign gpop_v[v] = igrant[v] && oreq[v];
        assign dpop_v[v] = (state_q[v] == VC_IDLE) && (cnt_q[v] != '0) && (head_type[v] != FT_HEAD);
        assign pop_v[v]  = gpop_v[v] || dpop_v[v];
        // A pop in the same cycle frees the slot, so a full VC still accepts the push.
        assign wr_v[v]   = push_v[v] && ((cnt_q[v] != CNT_FULL) || pop_v[v]);
        assign drop_v[v] = push_v[v] && !wr_v[v];

        assign oport[v*PORTW +: PORTW]           = port_q[v];
        assign odata[v*DATA_WIDTH +: DATA_WIDTH] = (cnt_q[v] != '0) ? head : '0;
    end

    assign oack = ack_q;
    assign olck = lck_q;
    assign oerr = err_q;

    always_comb begin
        err_d    = err_q || (|drop_v) || (|dpop_v);
        ack_d    = pop_v;
        lck_d    = lck_q;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        state_d  = state_q;
        port_d   = port_q;
        for (int v = 0; v < NVC; v++) begin
            if (wr_v[v]) begin
                mem_d[v][wr_ptr_q[v]] = idata;
                wr_ptr_d[v]           = ptr_inc(wr_ptr_q[v]);
            end
            if (pop_v[v]) rd_ptr_d[v] = ptr_inc(rd_ptr_q[v]);
            if (wr_v[v] && !pop_v[v]) cnt_d[v] = cnt_q[v] + CNTW'(1);
            else if (!wr_v[v] && pop_v[v]) cnt_d[v] = cnt_q[v] - CNTW'(1);

            // Clear before set so a new HEAD in the same cycle as the old TAIL pop keeps the lock.
            if (gpop_v[v] && head_type[v] == FT_TAIL) lck_d[v] = 1'b0;
            if (wr_v[v] && in_type == FT_HEAD)        lck_d[v] = 1'b1;

            case (state_q[v])
                VC_IDLE: begin
                    if (cnt_q[v] != '0 && head_type[v] == FT_HEAD) state_d[v] = VC_ROUTE;
                end
                VC_ROUTE: begin
                    port_d[v]  = route_port(head_dst[v]);
                    state_d[v] = VC_ACTIVE;
                end
                VC_ACTIVE: begin
                    if (gpop_v[v] && head_type[v] == FT_TAIL) state_d[v] = VC_IDLE;
                end
                default: state_d[v] = VC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int v = 0; v < NVC; v++) begin
                state_q[v]  <= VC_IDLE;
                rd_ptr_q[v] <= '0;
                wr_ptr_q[v] <= '0;
                cnt_q[v]    <= '0;
                port_q[v]   <= '0;
            end
            ack_q <= '0;
            lck_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            port_q   <= port_d;
            ack_q    <= ack_d;
            lck_q    <= lck_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: empty VCs never expose their entries.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_noc_input_vc_buffer.sv
// Bench for noc_input_vc_buffer: directed vector table, corner-case sequences and random traffic,
// all cross-checked every cycle against a queue-based reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_noc_input_vc_buffer;
    localparam int NDIM = 3, DW = 32, NVC = 4, VCW = 2, DEPTH = 5, PORTW = 2, RID = 5;
    localparam logic [1:0] T_NONE = 2'b00, T_HEAD = 2'b01, T_BODY = 2'b10, T_TAIL = 2'b11;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [DW-1:0]        idata;
    logic                 ivalid;
    logic [VCW-1:0]       ivch;
    logic [NVC-1:0]       igrant;
    logic [NVC-1:0]       oack, olck, oreq;
    logic [NVC*PORTW-1:0] oport;
    logic [NVC*DW-1:0]    odata;
    logic                 oerr;

    int n_vec = 0;
    int n_err = 0;

    noc_input_vc_buffer #(
        .ROUTERID(RID), .PORTID(1), .NDIM(NDIM), .DATA_WIDTH(DW), .NVC(NVC), .VCW(VCW),
        .DEPTH(DEPTH), .TYPE_MSB(31), .TYPE_LSB(30), .DST_LSB(0), .PORTW(PORTW)
    ) dut (
        .clk(clk), .reset(rst_n), .idata(idata), .ivalid(ivalid), .ivch(ivch),
        .oack(oack), .olck(olck), .oreq(oreq), .oport(oport), .odata(odata),
        .igrant(igrant), .oerr(oerr)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0]  mq [NVC][$];
    int             mphase [NVC];   // 0 idle, 1 routing, 2 active
    int             mport  [NVC];
    logic [NVC-1:0] mack, mlck;
    logic           merr;

    function automatic logic [DW-1:0] mk(input logic [1:0] t, input logic [2:0] d, input int tag);
        logic [DW-1:0] f;
        f        = '0;
        f[31:30] = t;
        f[29:8]  = tag[21:0];
        f[2:0]   = d;
        return f;
    endfunction

    function automatic logic [1:0] ftype(input logic [DW-1:0] f);
        return f[31:30];
    endfunction

    function automatic int route_of(input logic [DW-1:0] f);
        int diff;
        diff = int'(f[2:0]) ^ RID;
        if (diff == 0) return NDIM;
        for (int k = 0; k < NDIM; k++) if (((diff >> k) & 1) == 1) return k;
        return NDIM;
    endfunction

    task automatic model_edge();
        logic [NVC-1:0] gp, pp;
        int v;
        if (!rst_n) begin
            for (int i = 0; i < NVC; i++) begin
                mq[i].delete();
                mphase[i] = 0;
                mport[i]  = 0;
            end
            mack = '0; mlck = '0; merr = 1'b0;
            return;
        end
        for (int i = 0; i < NVC; i++) begin
            gp[i] = igrant[i] && mphase[i] == 2 && mq[i].size() > 0;
            pp[i] = gp[i] || (mphase[i] == 0 && mq[i].size() > 0 && ftype(mq[i][0]) != T_HEAD);
        end
        for (int i = 0; i < NVC; i++) begin
            if (mphase[i] == 0) begin
                if (mq[i].size() > 0) begin
                    if (ftype(mq[i][0]) == T_HEAD) mphase[i] = 1;
                    else merr = 1'b1;
                end
            end else if (mphase[i] == 1) begin
                mport[i]  = route_of(mq[i][0]);
                mphase[i] = 2;
            end else if (gp[i] && ftype(mq[i][0]) == T_TAIL) begin
                mphase[i] = 0;
                mlck[i]   = 1'b0;
            end
            if (pp[i]) void'(mq[i].pop_front());
        end
        mack = pp;
        if (ivalid && ftype(idata) != T_NONE) begin
            v = int'(ivch);
            if (mq[v].size() >= DEPTH) merr = 1'b1;
            else begin
                mq[v].push_back(idata);
                if (ftype(idata) == T_HEAD) mlck[v] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [NVC-1:0]       e_req;
        logic [NVC*PORTW-1:0] e_port;
        logic [NVC*DW-1:0]    e_data;
        for (int v = 0; v < NVC; v++) begin
            e_req[v]                = (mphase[v] == 2) && (mq[v].size() > 0);
            e_port[v*PORTW +: PORTW] = PORTW'(mport[v]);
            e_data[v*DW +: DW]      = (mq[v].size() > 0) ? mq[v][0] : '0;
        end
        chk("model oack", oack, mack);
        chk("model olck", olck, mlck);
        chk("model oreq", oreq, e_req);
        chk("model oport", oport, e_port);
        chk("model odata", odata, e_data);
        chk("model oerr", oerr, merr);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [1:0] ch, input logic [DW-1:0] d, input logic [3:0] g);
        ivalid = v; ivch = ch; idata = d; igrant = g;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'd0, '0, 4'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       vld;
        logic [1:0] vch;
        logic [1:0] typ;
        logic [2:0] dst;
        logic [3:0] gnt;
        logic [3:0] e_req;
        logic [3:0] e_ack;
        logic [3:0] e_lck;
        logic       e_err;
        logic [7:0] e_port;
    } vec_t;

    function automatic vec_t mkv(input logic vld, input logic [1:0] vch, input logic [1:0] typ,
                                 input logic [2:0] dst, input logic [3:0] gnt, input logic [3:0] e_req,
                                 input logic [3:0] e_ack, input logic [3:0] e_lck, input logic e_err,
                                 input logic [7:0] e_port);
        vec_t r;
        r.vld = vld; r.vch = vch; r.typ = typ; r.dst = dst; r.gnt = gnt;
        r.e_req = e_req; r.e_ack = e_ack; r.e_lck = e_lck; r.e_err = e_err; r.e_port = e_port;
        return r;
    endfunction

    vec_t tbl [18];
    int   acks;

    initial begin
        rst_n = 1'b0; ivalid = 1'b0; ivch = '0; idata = '0; igrant = '0;
        idle(2);
        chk("reset oreq", oreq, 4'h0);
        chk("reset olck", olck, 4'h0);
        chk("reset oport", oport, 8'h00);
        chk("reset odata", odata, '0);
        rst_n = 1'b1;

        // VC0: dest RID^100 -> port 2; VC2: dest RID -> local 3; VC1: dest RID^110 -> port 1
        tbl[0]  = mkv(1'b1, 2'd0, T_HEAD, 3'd1, 4'h0, 4'h0, 4'h0, 4'h1, 1'b0, 8'h00);
        tbl[1]  = mkv(1'b1, 2'd0, T_BODY, 3'd0, 4'h0, 4'h0, 4'h0, 4'h1, 1'b0, 8'h00);
        tbl[2]  = mkv(1'b1, 2'd0, T_BODY, 3'd0, 4'h0, 4'h1, 4'h0, 4'h1, 1'b0, 8'h02);
        tbl[3]  = mkv(1'b1, 2'd0, T_TAIL, 3'd0, 4'h1, 4'h1, 4'h1, 4'h1, 1'b0, 8'h02);
        tbl[4]  = mkv(1'b0, 2'd0, T_NONE, 3'd0, 4'h1, 4'h1, 4'h1, 4'h1, 1'b0, 8'h02);
        tbl[5]  = mkv(1'b0, 2'd0, T_NONE, 3'd0, 4'h1, 4'h1, 4'h1, 4'h1, 1'b0, 8'h02);
        tbl[6]  = mkv(1'b0, 2'd0, T_NONE, 3'd0, 4'h1, 4'h0, 4'h1, 4'h0, 1'b0, 8'h02);
        tbl[7]  = mkv(1'b0, 2'd0, T_NONE, 3'd0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 8'h02);
        tbl[8]  = mkv(1'b1, 2'd2, T_HEAD, 3'd5, 4'h0, 4'h0, 4'h0, 4'h4, 1'b0, 8'h02);
        tbl[9]  = mkv(1'b0, 2'd0, T_NONE, 3'd0, 4'h0, 4'h0, 4'h0, 4'h4, 1'b0, 8'h02);
        tbl[10] = mkv(1'b0, 2'd0, T_NONE, 3'd0, 4'h0, 4'h4, 4'h0, 4'h4, 1'b0, 8'h32);
        tbl[11] = mkv(1'b1, 2'd2, T_TAIL, 3'd0, 4'h4, 4'h4, 4'h4, 4'h4, 1'b0, 8'h32);
        tbl[12] = mkv(1'b0, 2'd0, T_NONE, 3'd0, 4'h4, 4'h0, 4'h4, 4'h0, 1'b0, 8'h32);
        tbl[13] = mkv(1'b1, 2'd1, T_HEAD, 3'd3, 4'h0, 4'h0, 4'h0, 4'h2, 1'b0, 8'h32);
        tbl[14] = mkv(1'b0, 2'd0, T_NONE, 3'd0, 4'h0, 4'h0, 4'h0, 4'h2, 1'b0, 8'h32);
        tbl[15] = mkv(1'b0, 2'd0, T_NONE, 3'd0, 4'h0, 4'h2, 4'h0, 4'h2, 1'b0, 8'h36);
        tbl[16] = mkv(1'b1, 2'd1, T_TAIL, 3'd0, 4'h2, 4'h2, 4'h2, 4'h2, 1'b0, 8'h36);
        tbl[17] = mkv(1'b0, 2'd0, T_NONE, 3'd0, 4'h2, 4'h0, 4'h2, 4'h0, 1'b0, 8'h36);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].vld, tbl[i].vch, mk(tbl[i].typ, tbl[i].dst, i), tbl[i].gnt);
            chk($sformatf("vec%0d oreq", i), oreq, tbl[i].e_req);
            chk($sformatf("vec%0d oack", i), oack, tbl[i].e_ack);
            chk($sformatf("vec%0d olck", i), olck, tbl[i].e_lck);
            chk($sformatf("vec%0d oerr", i), oerr, tbl[i].e_err);
            chk($sformatf("vec%0d oport", i), oport, tbl[i].e_port);
        end

        // Overflow: six flits into VC1 with no grant, the sixth is dropped.
        do_reset();
        drive(1'b1, 2'd1, mk(T_HEAD, 3'd1, 100), 4'h0);
        for (int k = 1; k <= 4; k++) drive(1'b1, 2'd1, mk(T_BODY, 3'd0, 100 + k), 4'h0);
        chk("ovf err before drop", oerr, 1'b0);
        drive(1'b1, 2'd1, mk(T_TAIL, 3'd0, 105), 4'h0);
        chk("ovf err", oerr, 1'b1);
        chk("ovf lck", olck[1], 1'b1);
        acks = 0;
        for (int k = 0; k < 5; k++) begin drive(1'b0, 2'd0, '0, 4'h2); acks += int'(oack[1]); end
        for (int k = 0; k < 3; k++) begin drive(1'b0, 2'd0, '0, 4'h2); acks += int'(oack[1]); end
        chk("ovf ack count", acks, 5);
        chk("ovf req drained", oreq[1], 1'b0);

        // Full VC3 with push and grant together every cycle.
        do_reset();
        drive(1'b1, 2'd3, mk(T_HEAD, 3'd0, 200), 4'h0);
        for (int k = 1; k <= 4; k++) drive(1'b1, 2'd3, mk(T_BODY, 3'd0, 200 + k), 4'h0);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 2'd3, mk((k == 9) ? T_TAIL : T_BODY, 3'd0, 205 + k), 4'h8);
            chk($sformatf("full order %0d", k), odata[3*DW +: DW], mk(T_BODY, 3'd0, 201 + k));
            chk($sformatf("full req %0d", k), oreq[3], 1'b1);
        end
        chk("full no err", oerr, 1'b0);
        acks = 0;
        for (int k = 0; k < 5; k++) begin drive(1'b0, 2'd0, '0, 4'h8); acks += int'(oack[3]); end
        chk("full drain acks", acks, 5);
        chk("full lck clear", olck[3], 1'b0);
        chk("full req clear", oreq[3], 1'b0);

        // Stray BODY on idle VC1 is discarded, then a proper packet routes.
        drive(1'b1, 2'd1, mk(T_BODY, 3'd0, 300), 4'h0);
        chk("stray req0", oreq[1], 1'b0);
        idle(1);
        chk("stray ack", oack[1], 1'b1);
        chk("stray err", oerr, 1'b1);
        chk("stray req1", oreq[1], 1'b0);
        idle(1);
        chk("stray ack once", oack[1], 1'b0);
        drive(1'b1, 2'd1, mk(T_HEAD, 3'd1, 301), 4'h0);
        idle(1);
        chk("after stray req early", oreq[1], 1'b0);
        idle(1);
        chk("after stray req", oreq[1], 1'b1);
        chk("after stray port", oport[3:2], 2'd2);
        drive(1'b1, 2'd1, mk(T_TAIL, 3'd0, 302), 4'h2);
        drive(1'b0, 2'd0, '0, 4'h2);
        chk("after stray lck", olck[1], 1'b0);

        // Interleaved VC0/VC3 packets cut by reset.
        drive(1'b1, 2'd0, mk(T_HEAD, 3'd1, 400), 4'h0);
        drive(1'b1, 2'd3, mk(T_HEAD, 3'd5, 401), 4'h0);
        drive(1'b1, 2'd0, mk(T_BODY, 3'd0, 402), 4'h0);
        drive(1'b1, 2'd3, mk(T_BODY, 3'd0, 403), 4'h9);
        rst_n = 1'b0;
        drive(1'b1, 2'd0, mk(T_HEAD, 3'd2, 404), 4'hf);
        rst_n = 1'b1;
        chk("midrst oack", oack, 4'h0);
        chk("midrst olck", olck, 4'h0);
        chk("midrst oreq", oreq, 4'h0);
        chk("midrst oport", oport, 8'h00);
        chk("midrst odata", odata, '0);
        chk("midrst oerr", oerr, 1'b0);
        drive(1'b1, 2'd3, mk(T_HEAD, 3'd1, 500), 4'h0);
        idle(2);
        chk("fresh req", oreq, 4'h8);
        chk("fresh port", oport, 8'h80);
        drive(1'b1, 2'd3, mk(T_TAIL, 3'd0, 501), 4'h8);
        drive(1'b0, 2'd0, '0, 4'h8);
        chk("fresh lck", olck, 4'h0);
        chk("fresh req done", oreq, 4'h0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst_n  = ($urandom_range(199) != 0);
            ivalid = ($urandom_range(3) != 0);
            ivch   = VCW'($urandom_range(NVC - 1));
            idata  = mk(2'($urandom_range(3)), 3'($urandom_range(7)), c);
            igrant = 4'($urandom_range(15));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/noc_input_vc_buffer.md
Name: noc_input_vc_buffer

Overview:
- Receive end of the inter-router link; mirrors the output-channel/credit logic on the sending router.
- Accepts flits tagged with a virtual channel (VC) and stores each in a per-VC FIFO.
- Computes the hypercube output port for each packet from its head flit and presents per-VC requests to the switch allocator.
- Returns per-VC flit acks (credits) and per-VC lock status to the upstream output channel.

Parameters:
- ROUTERID, 0: this router's hypercube address, NDIM bits.
- PORTID, 0: input port index; informational only, no functional effect.
- NDIM, 3: hypercube dimensions; local port index = NDIM.
- DATA_WIDTH, 32: flit width.
- NVC, 4: number of virtual channels.
- VCW, 2: VC index width.
- DEPTH, 5: FIFO entries per VC.
- TYPE_MSB/TYPE_LSB, 31/30: flit type field. Encodings: 01 HEAD, 10 BODY, 11 TAIL, 00 NONE.
- DST_LSB, 0: LSB of the destination field in a HEAD flit; field is NDIM bits wide.
- PORTW, 2: output port index width; must hold the value NDIM.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- idata  in  DATA_WIDTH  flit from upstream.
- ivalid  in  1  flit valid.
- ivch  in  VCW  VC of the incoming flit.
- oack  out  NVC  one-cycle credit return per popped flit.
- olck  out  NVC  VC holds an unfinished packet.
- oreq  out  NVC  request to switch allocator.
- oport  out  NVC*PORTW  routed output port per VC; VC v occupies bits [v*PORTW +: PORTW].
- odata  out  NVC*DATA_WIDTH  FIFO head flit per VC.
- igrant  in  NVC  allocator grant; pops the head flit of that VC.
- oerr  out  1  sticky protocol/overflow error.

Behaviour:
- Clock and reset: clk; reset synchronous, active-low.
- Reset effects:
  - all FIFOs emptied (pointers and counts 0);
  - all VC states IDLE;
  - oack, olck, oreq, oport, oerr = 0;
  - odata = 0 while the VC is empty.
- Reset mid-packet discards all buffered flits; no acks are issued for them.
- Push: ivalid=1 writes idata into FIFO[ivch] at the clock edge.
  - Push into a full FIFO drops the flit and sets oerr.
  - ivalid with type NONE is ignored.
- Pop: igrant[v] while oreq[v]=1 removes the head flit at the edge.
  - igrant when oreq=0 is ignored.
  - Simultaneous push and pop on the same VC keeps the count unchanged; this must work when the FIFO is full.
- Pointers wrap modulo DEPTH; count is 0..DEPTH.
- oack[v] is registered: it pulses 1 for exactly one cycle after each pop of VC v, including internal discard pops.
- Per-VC FSM:
  - IDLE: FIFO non-empty and head type HEAD -> ROUTE. Head type BODY/TAIL -> discard-pop the flit, set oerr, stay IDLE.
  - ROUTE (1 cycle): latch oport[v] from the head flit, then -> ACTIVE.
    - diff = dest ^ ROUTERID.
    - diff == 0 -> port NDIM (local).
    - otherwise -> index of the lowest set bit of diff.
  - ACTIVE: oreq[v] = (count != 0). On a granted pop of a TAIL flit -> IDLE; oport holds until the next ROUTE.
- Latency: a HEAD written at edge t reaches the FIFO head at t; the FSM enters ROUTE at t+1; oreq rises at t+2.
- odata[v] is combinational from the FIFO head entry.
- olck[v]:
  - set at the edge a HEAD is pushed to VC v;
  - cleared at the edge the matching TAIL is popped;
  - if the pop of a TAIL and the push of a new HEAD on the same VC occur in the same cycle, set wins.
- oerr is cleared only by reset.
- VCs are fully independent; all may push, pop and route concurrently. Only one push per cycle, since the link is single.

Test Plan:
- Reset, then 4-flit packet on VC0 with dest = ROUTERID^3'b100:
  - oreq[0] rises 2 cycles after the head push; oport[0] = 2.
  - With igrant held, four oack[0] pulses follow.
  - olck[0] falls the cycle after the tail pop.
- Head with dest == ROUTERID on VC2 -> oport[2] = 3 (local).
- Head with dest = ROUTERID^3'b110 -> oport = 1 (lowest set bit).
- 6 flits into VC1 with no grants (DEPTH=5): the 6th is dropped, oerr=1, count stays 5. Then grant 5 cycles -> exactly 5 oack[1] pulses.
- Full VC3, simultaneous push and grant each cycle for 10 cycles: count stays 5, no drop, flit order preserved.
- BODY flit arriving on idle VC1:
  - discarded, oack[1] pulses once, oerr=1, oreq[1] never asserts.
  - A subsequent valid packet on VC1 routes normally.
- Interleaved packets on VC0 and VC3 with reset asserted mid-packet: all outputs 0 the next cycle; a fresh packet afterwards is handled normally.
